vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 89 ++++++++
 tb/tb_vga_timing.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// VGA timing generator: 25 MHz pixel strobe from the 100 MHz clk, h/v counters, registered syncs.
// Optional frame strobe f_tick is built only when VGA_FRAME_TICK_EN is defined.
module vga_timing #(
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic       p_tick,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync
`ifdef VGA_FRAME_TICK_EN
   ,output logic      f_tick
`endif
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [1:0] div_q, div_d;
   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;

   assign p_tick = (div_q == 2'd3);

   // Syncs are decoded from the next counts so they register on the same edge as x/y.
   always_comb begin
      div_d = div_q + 2'd1;
      x_d   = x_q;
      y_d   = y_q;
      if (p_tick) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
      end
      hsync_d = !((x_d >= HS_START) && (x_d <= HS_END));
      vsync_d = !((y_d >= VS_START) && (y_d <= VS_END));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
      end else begin
         div_q   <= div_d;
         x_q     <= x_d;
         y_q     <= y_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign x        = x_q;
   assign y        = y_q;
   assign hsync    = hsync_q;
   assign vsync    = vsync_q;
   assign video_on = (x_q < H_VIS) && (y_q < V_VIS);

`ifdef VGA_FRAME_TICK_EN
   assign f_tick = p_tick && (x_q == H_VIS - 10'd1) && (y_q == V_VIS - 10'd1);
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing on a shrunken timing set; expectations derive from the
// absolute clk count since reset release. Define VGA_FRAME_TICK_EN to cover f_tick.
module tb_vga_timing;

   localparam int unsigned HD = 8, HF = 2, HS = 3, HB = 2;
   localparam int unsigned VD = 6, VF = 1, VS = 2, VB = 2;
   localparam int unsigned HT = HD + HF + HS + HB;
   localparam int unsigned VT = VD + VF + VS + VB;
   localparam int unsigned FRAME_CLKS = HT * VT * 4;

   typedef struct packed {
      logic       p;
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       vo;
      logic       f;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       p_tick;
   logic [9:0] x, y;
   logic       video_on, hsync, vsync;
   logic       f_tick_w;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned n     = 0;
   bit          in_reset = 1'b1;
   bit          win = 1'b0;
   int unsigned cnt_vid = 0, cnt_hs = 0, cnt_vs = 0, cnt_f = 0;
   exp_t        q[$];

   vga_timing #(
      .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .p_tick   (p_tick),
      .x        (x),
      .y        (y),
      .video_on (video_on),
      .hsync    (hsync),
      .vsync    (vsync)
`ifdef VGA_FRAME_TICK_EN
      ,.f_tick  (f_tick_w)
`endif
   );

`ifndef VGA_FRAME_TICK_EN
   assign f_tick_w = 1'b0;
`endif

   always #5 clk = ~clk;

   function automatic exp_t reset_exp();
      exp_t e;
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.vo = 1'b1;
      return e;
   endfunction

   // n = rising edges since release; pixel index t = n/4 positions the beam in raster order.
   function automatic exp_t model(int unsigned edges);
      exp_t e;
      int unsigned t, px, py;
      t  = edges / 4;
      px = t % HT;
      py = (t / HT) % VT;
      e.p  = (edges % 4) == 3;
      e.x  = 10'(px);
      e.y  = 10'(py);
      e.hs = !(px >= HD + HF && px < HD + HF + HS);
      e.vs = !(py >= VD + VF && py < VD + VF + VS);
      e.vo = (px < HD) && (py < VD);
`ifdef VGA_FRAME_TICK_EN
      e.f  = e.p && (px == HD - 1) && (py == VD - 1);
`else
      e.f  = 1'b0;
`endif
      return e;
   endfunction

   task automatic run_cycles(int unsigned k);
      repeat (k) begin
         @(posedge clk);
         if (in_reset) q.push_back(reset_exp());
         else begin
            n++;
            q.push_back(model(n));
         end
      end
   endtask

   task automatic do_reset(int unsigned k);
      @(negedge clk);
      #2;
      q.push_back(reset_exp());
      reset    = 1'b0;
      in_reset = 1'b1;
      run_cycles(k);
      @(negedge clk);
      #2;
      reset    = 1'b1;
      in_reset = 1'b0;
      n        = 0;
   endtask

   task automatic check_eq(string name, int unsigned act, int unsigned req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: samples 1 time unit after each clk falling edge and after reset assertion.
   initial begin
      exp_t e, a;
      forever begin
         @(negedge clk or negedge reset);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            a = {p_tick, x, y, hsync, vsync, video_on, f_tick_w};
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL cycle_check t=%0t n=%0d: got p=%b x=%0d y=%0d hs=%b vs=%b vo=%b f=%b, expected p=%b x=%0d y=%0d hs=%b vs=%b vo=%b f=%b",
                        $time, n, a.p, a.x, a.y, a.hs, a.vs, a.vo, a.f,
                        e.p, e.x, e.y, e.hs, e.vs, e.vo, e.f);
            end
            if (win) begin
               if (p_tick) begin
                  cnt_vid += int'(video_on);
                  cnt_hs  += int'(!hsync);
                  cnt_vs  += int'(!vsync);
               end
               cnt_f += int'(f_tick_w);
            end
         end
      end
   end

   initial begin
      int unsigned tgt;
      reset    = 1'b0;
      in_reset = 1'b1;
      run_cycles(3);
      @(negedge clk);
      #2;
      reset    = 1'b1;
      in_reset = 1'b0;
      n        = 0;

      win = 1'b1;
      run_cycles(2 * FRAME_CLKS);
      win = 1'b0;
      @(negedge clk);
      #2;
      check_eq("video_on_ticks", cnt_vid, 2 * HD * VD);
      check_eq("hsync_low_ticks", cnt_hs, 2 * VT * HS);
      check_eq("vsync_low_ticks", cnt_vs, 2 * VS * HT);
`ifdef VGA_FRAME_TICK_EN
      check_eq("f_tick_pulses", cnt_f, 2);
`endif

      // Park inside both sync pulses, then reset asynchronously.
      do_reset(2);
      tgt = (VD + VF) * HT + (HD + HF + 1);
      run_cycles(4 * tgt + 1);
      do_reset(3);

      repeat (20) begin
         run_cycles($urandom_range(1, 800));
         if ($urandom_range(0, 2) == 0) do_reset($urandom_range(1, 4));
      end
      @(negedge clk);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
